// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Definitions shared by the LPDDR2 bridge and its read buffer.
//   state_t          bridge FSM states (INIT, IDLE, WR, RD, RWAIT, DONE)
//   LPDDR2_ADDR_W    word address width of the memory master
//   LPDDR2_DATA_W    data word width
//   DEFAULT_TIMEOUT  cycles without a controller response before err is raised
//   is_busy()        true in the states where a controller transaction is open
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int LPDDR2_ADDR_W   = 27;
    localparam int LPDDR2_DATA_W   = 32;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR,
        RD,
        RWAIT,
        DONE
    } state_t;

    // States in which the timeout counter runs.
    function automatic logic is_busy(input state_t s);
        return (s == WR) || (s == RD) || (s == RWAIT);
    endfunction

endpackage

// File: rtl/read_buffer.sv
// -----------------------------------------------------------------------------
// read_buffer
// One-entry read buffer: a single address/data/valid register that lets the
// bridge answer a repeated read without touching DRAM.
//   clk, rst      clock, asynchronous active-low reset (invalidates the entry)
//   lookup_addr   address to compare against the stored entry
//   hit           entry valid and its address equals lookup_addr
//   buf_data      stored data word
//   fill_*        load a complete new entry (read completion)
//   wt_*          write-through: update the data only if wt_addr is the
//                 address currently held
// -----------------------------------------------------------------------------
module read_buffer
    import mem_pkg::*;
#(
    parameter int ADDR_W = LPDDR2_ADDR_W,
    parameter int DATA_W = LPDDR2_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] buf_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              wt_en,
    input  logic [ADDR_W-1:0] wt_addr,
    input  logic [DATA_W-1:0] wt_data
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // NOTE: only valid_q has to be cleared for correctness; address and data
    // are reset too because the entry is a single word and it keeps
    // read_data/hit free of X after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (fill_en) begin
                valid_q <= 1'b1;
                addr_q  <= fill_addr;
                data_q  <= fill_data;
            end else if (wt_en && valid_q && (addr_q == wt_addr)) begin
                data_q <= wt_data;
            end
        end
    end

    assign hit      = valid_q && (addr_q == lookup_addr);
    assign buf_data = data_q;

endmodule

// File: rtl/lpddr2_bridge.sv
// -----------------------------------------------------------------------------
// lpddr2_bridge
// Turns the memory master's level-style read/write requests into handshaked
// Avalon-MM transactions for the LPDDR2 controller, returns read data and a
// stall to the CPU, and serves repeated reads of the same word from a
// one-entry write-through buffer.
//   clk, rst          clock, asynchronous active-low reset
//   address           word address from the memory master
//   write_data        store data
//   read_req          read request (level)
//   write_req         write request (level, wins over read_req)
//   read_data         read result (buffer hit: combinational from the buffer)
//   stall             CPU must hold its state while high
//   err               sticky controller timeout flag
//   avl_ready         controller calibration done (only consulted in INIT)
//   avl_addr/avl_wdata/avl_read/avl_write/avl_be   Avalon master outputs
//   avl_waitrequest/avl_rdata/avl_rdata_valid      Avalon master inputs
// -----------------------------------------------------------------------------
module lpddr2_bridge
    import mem_pkg::*;
#(
    parameter int ADDR_W  = LPDDR2_ADDR_W,
    parameter int DATA_W  = LPDDR2_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                read_req,
    input  logic                write_req,
    output logic [DATA_W-1:0]   read_data,
    output logic                stall,
    output logic                err,
    input  logic                avl_ready,
    output logic [ADDR_W-1:0]   avl_addr,
    output logic [DATA_W-1:0]   avl_wdata,
    output logic                avl_read,
    output logic                avl_write,
    output logic [DATA_W/8-1:0] avl_be,
    input  logic                avl_waitrequest,
    input  logic [DATA_W-1:0]   avl_rdata,
    input  logic                avl_rdata_valid
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic [DATA_W-1:0] read_data_q;
    logic [ADDR_W-1:0] avl_addr_q;
    logic [DATA_W-1:0] avl_wdata_q;
    logic              avl_read_q;
    logic              avl_write_q;
    logic              err_q;

    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;

    logic              start_wr;
    logic              start_rd;
    logic              wr_done;
    logic              rd_capture;
    logic              timeout_hit;
    logic              tmo_expired;

    // Last busy cycle before the transaction is abandoned; a completion that
    // lands in that same cycle still wins.
    assign tmo_expired = (tmo_cnt_q == CNT_LAST);

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        start_wr    = 1'b0;
        start_rd    = 1'b0;
        wr_done     = 1'b0;
        rd_capture  = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            INIT: begin
                stall = read_req | write_req;
                if (avl_ready) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                stall = write_req | (read_req & ~buf_hit);
                if (write_req) begin
                    start_wr = 1'b1;
                    state_d  = WR;
                end else if (read_req && !buf_hit) begin
                    start_rd = 1'b1;
                    state_d  = RD;
                end
            end

            WR: begin
                stall = 1'b1;
                if (!avl_waitrequest) begin
                    wr_done = 1'b1;
                    state_d = DONE;
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end

            RD: begin
                stall = 1'b1;
                if (!avl_waitrequest) begin
                    // Controllers with zero read latency return data in the
                    // accept cycle; skip RWAIT in that case.
                    if (avl_rdata_valid) begin
                        rd_capture = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = RWAIT;
                    end
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end

            RWAIT: begin
                stall = 1'b1;
                if (avl_rdata_valid) begin
                    rd_capture = 1'b1;
                    state_d    = DONE;
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                // The CPU advances on this edge; any request seen now is the
                // old one and is ignored.
                state_d = IDLE;
            end

            default: begin
                state_d = INIT;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            tmo_cnt_q   <= '0;
            read_data_q <= '0;
            avl_addr_q  <= '0;
            avl_wdata_q <= '0;
            avl_read_q  <= 1'b0;
            avl_write_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;

            // Strobes are high exactly while the FSM sits in the state that
            // owns them, which also drops them on accept and on timeout.
            avl_read_q  <= (state_d == RD);
            avl_write_q <= (state_d == WR);

            if (start_wr) begin
                avl_addr_q  <= address;
                avl_wdata_q <= write_data;
            end else if (start_rd) begin
                avl_addr_q <= address;
            end

            // Counts the whole WR / RD+RWAIT span, cleared on leaving it.
            if (is_busy(state_q) && is_busy(state_d)) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end else begin
                tmo_cnt_q <= '0;
            end

            if (timeout_hit) begin
                err_q       <= 1'b1;
                read_data_q <= '1;
            end else if (rd_capture) begin
                read_data_q <= avl_rdata;
            end
        end
    end

    read_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_read_buffer (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (address),
        .hit         (buf_hit),
        .buf_data    (buf_data),
        .fill_en     (rd_capture),
        .fill_addr   (avl_addr_q),
        .fill_data   (avl_rdata),
        .wt_en       (wr_done),
        .wt_addr     (avl_addr_q),
        .wt_data     (avl_wdata_q)
    );

    // A hit in IDLE is answered in the same cycle, straight from the buffer.
    assign read_data = ((state_q == IDLE) && read_req && buf_hit) ? buf_data : read_data_q;
    assign err       = err_q;
    assign avl_addr  = avl_addr_q;
    assign avl_wdata = avl_wdata_q;
    assign avl_read  = avl_read_q;
    assign avl_write = avl_write_q;
    assign avl_be    = '1;

endmodule

// File: tb/tb_lpddr2_bridge.sv
// -----------------------------------------------------------------------------
// tb_lpddr2_bridge
// Directed bench for lpddr2_bridge (TIMEOUT = 16). The bench plays both the
// memory master and the controller. A transaction-level model (buffer entry
// and error flag) plus per-transaction latency arithmetic sets the expected
// outputs for every cycle; one negedge process compares them. Literal checks
// at key points pin the model.
// -----------------------------------------------------------------------------
module tb_lpddr2_bridge;

    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic          read_req;
    logic          write_req;
    logic [DW-1:0] read_data;
    logic          stall;
    logic          err;
    logic          avl_ready;
    logic [AW-1:0] avl_addr;
    logic [DW-1:0] avl_wdata;
    logic          avl_read;
    logic          avl_write;
    logic [3:0]    avl_be;
    logic          avl_waitrequest;
    logic [DW-1:0] avl_rdata;
    logic          avl_rdata_valid;

    always #5 clk = ~clk;

    lpddr2_bridge #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .address         (address),
        .write_data      (write_data),
        .read_req        (read_req),
        .write_req       (write_req),
        .read_data       (read_data),
        .stall           (stall),
        .err             (err),
        .avl_ready       (avl_ready),
        .avl_addr        (avl_addr),
        .avl_wdata       (avl_wdata),
        .avl_read        (avl_read),
        .avl_write       (avl_write),
        .avl_be          (avl_be),
        .avl_waitrequest (avl_waitrequest),
        .avl_rdata       (avl_rdata),
        .avl_rdata_valid (avl_rdata_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what the buffer holds and whether a timeout has happened.
    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_err;

    // Expected outputs for the current cycle.
    bit            chk_en = 1'b0;
    logic          exp_stall;
    logic          exp_read;
    logic          exp_write;
    logic          exp_err;
    logic          exp_addr_chk;
    logic [AW-1:0] exp_addr;
    logic          exp_wdata_chk;
    logic [DW-1:0] exp_wdata;
    logic          exp_rd_chk;
    logic [DW-1:0] exp_rdata;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", DW'(stall), DW'(exp_stall));
            check("avl_read", DW'(avl_read), DW'(exp_read));
            check("avl_write", DW'(avl_write), DW'(exp_write));
            check("err", DW'(err), DW'(exp_err));
            check("avl_be", DW'(avl_be), 32'h0000000F);
            if (exp_addr_chk)  check("avl_addr", DW'(avl_addr), DW'(exp_addr));
            if (exp_wdata_chk) check("avl_wdata", avl_wdata, exp_wdata);
            if (exp_rd_chk)    check("read_data", read_data, exp_rdata);
        end
    end

    // One cycle = step into it, then set inputs and expectations for it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input logic s, input logic r, input logic w);
        exp_stall     = s;
        exp_read      = r;
        exp_write     = w;
        exp_err       = m_err;
        exp_addr_chk  = 1'b0;
        exp_wdata_chk = 1'b0;
        exp_rd_chk    = 1'b0;
    endtask

    // Read of address a. On a miss the controller holds waitrequest for
    // n_wait cycles, then returns rdata d cycles after accept (d < 0: never).
    // Leaves the bench positioned inside the hit cycle or the DONE cycle.
    task automatic do_read(input logic [AW-1:0] a, input int n_wait, input int d,
                           input logic [DW-1:0] rdata);
        int busy;
        bit timed_out;
        step();
        address         = a;
        read_req        = 1'b1;
        write_req       = 1'b0;
        avl_rdata_valid = 1'b0;
        if (m_valid && (m_addr == a)) begin
            expect_cycle(1'b0, 1'b0, 1'b0);
            exp_rd_chk = 1'b1;
            exp_rdata  = m_data;
            return;
        end
        expect_cycle(1'b1, 1'b0, 1'b0);
        busy      = n_wait + 1 + ((d < 0) ? TMO : d);
        timed_out = (busy > TMO);
        if (timed_out) busy = TMO;
        for (int i = 0; i < busy; i++) begin
            step();
            avl_waitrequest = (i < n_wait);
            avl_rdata_valid = (d >= 0) && (i == n_wait + d);
            avl_rdata       = avl_rdata_valid ? rdata : 32'h5A5A0000 + DW'(i);
            expect_cycle(1'b1, (i <= n_wait), 1'b0);
            exp_addr_chk = 1'b1;
            exp_addr     = a;
        end
        step();
        avl_waitrequest = 1'b1;
        avl_rdata_valid = 1'b0;
        if (timed_out) begin
            m_err = 1'b1;
        end else begin
            m_valid = 1'b1;
            m_addr  = a;
            m_data  = rdata;
        end
        expect_cycle(1'b0, 1'b0, 1'b0);
        exp_rd_chk = 1'b1;
        exp_rdata  = timed_out ? 32'hFFFFFFFF : rdata;
    endtask

    // Write with n_wait waitrequest cycles; optionally with read_req also high.
    // Leaves the bench positioned inside the DONE cycle.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] data,
                            input int n_wait, input logic also_read);
        int busy;
        bit timed_out;
        step();
        address    = a;
        write_data = data;
        write_req  = 1'b1;
        read_req   = also_read;
        expect_cycle(1'b1, 1'b0, 1'b0);
        busy      = n_wait + 1;
        timed_out = (busy > TMO);
        if (timed_out) busy = TMO;
        for (int i = 0; i < busy; i++) begin
            step();
            avl_waitrequest = (i < n_wait);
            expect_cycle(1'b1, 1'b0, 1'b1);
            exp_addr_chk  = 1'b1;
            exp_addr      = a;
            exp_wdata_chk = 1'b1;
            exp_wdata     = data;
        end
        step();
        avl_waitrequest = 1'b1;
        if (timed_out) begin
            m_err = 1'b1;
        end else if (m_valid && (m_addr == a)) begin
            m_data = data;
        end
        expect_cycle(1'b0, 1'b0, 1'b0);
    endtask

    // CPU has moved on: requests dropped, bridge idle.
    task automatic finish_txn();
        step();
        read_req        = 1'b0;
        write_req       = 1'b0;
        avl_waitrequest = 1'b1;
        avl_rdata_valid = 1'b0;
        expect_cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        address         = 27'h0000ABC;
        write_data      = '0;
        read_req        = 1'b1;
        write_req       = 1'b0;
        avl_ready       = 1'b0;
        avl_waitrequest = 1'b1;
        avl_rdata       = '0;
        avl_rdata_valid = 1'b0;
        m_valid         = 1'b0;
        m_addr          = '0;
        m_data          = '0;
        m_err           = 1'b0;

        // Reset with controller not ready and a read pending.
        #2 rst = 1'b0;
        expect_cycle(1'b1, 1'b0, 1'b0);
        exp_addr_chk  = 1'b1;
        exp_addr      = '0;
        exp_wdata_chk = 1'b1;
        exp_wdata     = '0;
        exp_rd_chk    = 1'b1;
        exp_rdata     = '0;
        chk_en        = 1'b1;
        repeat (2) step();
        step();
        rst = 1'b1;
        repeat (2) step();
        step();
        avl_ready = 1'b1;

        // First read after INIT: minimum latency (accept at once, data next cycle).
        do_read(27'h0000ABC, 0, 1, 32'h0BADF00D);
        #2 check("lit_init_read", read_data, 32'h0BADF00D);
        finish_txn();
        avl_ready = 1'b0;   // falling after INIT must not matter

        // Read miss with 2 waitrequest cycles, data 3 cycles after accept.
        do_read(27'h0001000, 2, 3, 32'hDEADBEEF);
        #2 check("lit_miss_data", read_data, 32'hDEADBEEF);
        check("lit_miss_done_stall", DW'(stall), 32'h0);
        finish_txn();

        // Repeated read hits the buffer.
        do_read(27'h0001000, 0, 0, 32'h0);
        #2 check("lit_hit_data", read_data, 32'hDEADBEEF);
        check("lit_hit_stall", DW'(stall), 32'h0);
        finish_txn();

        // Write-through to the buffered address, then hit.
        do_write(27'h0001000, 32'h12345678, 2, 1'b0);
        finish_txn();
        do_read(27'h0001000, 0, 0, 32'h0);
        #2 check("lit_wt_hit", read_data, 32'h12345678);
        finish_txn();

        // Write and read together: write first, read issued after DONE.
        do_write(27'h0002000, 32'hCAFEF00D, 0, 1'b1);
        do_read(27'h0002000, 0, 1, 32'hCAFEF00D);
        #2 check("lit_rw_read", read_data, 32'hCAFEF00D);
        finish_txn();

        // Spurious rdata_valid while idle must not disturb the buffer.
        step();
        avl_rdata_valid = 1'b1;
        avl_rdata       = 32'h55555555;
        expect_cycle(1'b0, 1'b0, 1'b0);
        finish_txn();
        do_read(27'h0002000, 0, 0, 32'h0);
        finish_txn();

        // Write elsewhere leaves the buffer alone.
        do_write(27'h0004000, 32'h11111111, 1, 1'b0);
        finish_txn();
        do_read(27'h0002000, 0, 0, 32'h0);
        #2 check("lit_other_write_hit", read_data, 32'hCAFEF00D);
        finish_txn();

        // Read timeout: data never returned.
        do_read(27'h0003000, 0, -1, 32'h0);
        #2 check("lit_tmo_err", DW'(err), 32'h1);
        check("lit_tmo_data", read_data, 32'hFFFFFFFF);
        check("lit_tmo_stall", DW'(stall), 32'h0);
        finish_txn();
        repeat (2) finish_txn();
        do_read(27'h0002000, 0, 0, 32'h0);   // buffer survived, err still set
        finish_txn();

        // Write timeout: waitrequest never drops.
        do_write(27'h0006000, 32'h99999999, 100, 1'b0);
        finish_txn();

        // Reset in the middle of a read.
        step();
        address         = 27'h0005000;
        read_req        = 1'b1;
        avl_waitrequest = 1'b1;
        expect_cycle(1'b1, 1'b0, 1'b0);
        step();
        expect_cycle(1'b1, 1'b1, 1'b0);
        exp_addr_chk = 1'b1;
        exp_addr     = 27'h0005000;
        #2 check("lit_rd_before_rst", DW'(avl_read), 32'h1);
        rst     = 1'b0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        #1 check("lit_rd_after_rst", DW'(avl_read), 32'h0);
        check("lit_err_after_rst", DW'(err), 32'h0);
        expect_cycle(1'b1, 1'b0, 1'b0);
        exp_addr_chk = 1'b1;
        exp_addr     = '0;
        exp_rd_chk   = 1'b1;
        exp_rdata    = '0;
        step();
        rst       = 1'b1;
        avl_ready = 1'b1;
        expect_cycle(1'b1, 1'b0, 1'b0);
        do_read(27'h0002000, 0, 1, 32'h77777777);   // buffer was invalidated
        #2 check("lit_after_rst_read", read_data, 32'h77777777);
        finish_txn();

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lpddr2_bridge.md
Name: lpddr2_bridge

Overview:
- Downstream of the memory master: converts its level-style LPDDR2 request lines (read_req/write_req/address/write_data) into handshaked Avalon-MM transactions for the LPDDR2 controller.
- Returns read_data and a stall to the CPU.
- Keeps a one-entry write-through read buffer, so the continuously asserted read_req during fetch does not re-read DRAM.

Parameters:
- ADDR_W, 27, word address width (matches the memory master's address output).
- DATA_W, 32, data word width.
- TIMEOUT, 1024, cycles without controller response before the error flag is raised.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- address  in  ADDR_W  word address from the memory master
- write_data  in  DATA_W  store data
- read_req  in  1  read request (level)
- write_req  in  1  write request (level; has priority over read_req)
- read_data  out  DATA_W  read result to the memory master
- stall  out  1  CPU must hold state while high
- err  out  1  sticky timeout flag
- avl_ready  in  1  controller calibration/init done
- avl_addr  out  ADDR_W  Avalon address
- avl_wdata  out  DATA_W  Avalon write data
- avl_read  out  1  Avalon read strobe
- avl_write  out  1  Avalon write strobe
- avl_be  out  DATA_W/8  byte enables; always all ones
- avl_waitrequest  in  1  controller back-pressure
- avl_rdata  in  DATA_W  controller read data
- avl_rdata_valid  in  1  read data valid

Behaviour:
- Reset (rst low, asynchronous): state=INIT; avl_read=avl_write=0; avl_addr=avl_wdata=0; read_data=0; buffer valid=0; err=0; timeout counter=0.
- Stall:
  - INIT: stall=1 whenever read_req or write_req is high.
  - IDLE: stall = write_req | (read_req & miss).
  - WR, RD, RWAIT: stall=1.
  - DONE: stall=0.
- States:
  - INIT: wait for avl_ready=1, then go to IDLE.
  - IDLE, write_req=1: register address/write_data into avl_addr/avl_wdata, assert avl_write, go to WR.
  - IDLE, read_req=1 and miss: register address, assert avl_read, go to RD.
  - IDLE, read_req=1 and hit (valid and buffered address == address): stay in IDLE. read_data is driven combinationally from the buffer with zero latency.
  - WR: hold avl_write and operands until a cycle with avl_waitrequest=0. Then deassert avl_write and go to DONE. If the buffer address equals the written address, update buffer data (write-through). Otherwise leave the buffer unchanged.
  - RD: hold avl_read until avl_waitrequest=0, then deassert and go to RWAIT. If avl_rdata_valid is already high in the accept cycle, capture and go directly to DONE.
  - RWAIT: on avl_rdata_valid=1, capture avl_rdata into the buffer data and read_data, set buffer address and valid=1, go to DONE.
  - DONE: exactly one cycle. Requests are ignored (the CPU advances on this edge). Return to IDLE.
- Minimum latencies: write = 2 cycles of stall then 1 DONE cycle; read miss = 3 cycles of stall with zero wait states and valid one cycle after accept.
- Timeout: the counter increments each cycle in WR, RD or RWAIT and clears on leaving those states. When it reaches TIMEOUT:
  - set err (sticky until reset);
  - drop avl_read/avl_write;
  - go to DONE with read_data=all ones;
  - leave the buffer unchanged.
- Simultaneous write_req and read_req: the write is serviced; the read is re-evaluated after DONE.
- Spurious avl_rdata_valid outside RD/RWAIT: ignored.
- avl_ready falling after INIT: ignored; the controller's waitrequest governs.
- Reset mid-transaction: strobes drop immediately and the buffer is invalidated.
- avl_be is constant all ones.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (INIT, IDLE, WR, RD, RWAIT, DONE);
  - LPDDR2_ADDR_W=27;
  - the default TIMEOUT constant.
- One natural sub-module: read_buffer. It holds the one-entry address/data/valid register with hit compare, fill port and write-through update port.

Test Plan:
- Reset with avl_ready=0 and read_req=1 -> stall=1 and no avl_read. Raise avl_ready -> state IDLE, then avl_read with avl_addr = request address.
- Read miss at 0x0001000 with 2 waitrequest cycles, avl_rdata=0xDEADBEEF valid 3 cycles after accept -> stall high for the whole span; read_data=0xDEADBEEF in DONE; stall=0 in DONE.
- Repeated read of 0x0001000 after the fill -> stall=0, read_data=0xDEADBEEF, no avl_read pulse.
- Write 0x12345678 to 0x0001000 -> avl_write held through waitrequest, one DONE cycle. A subsequent read hits and returns 0x12345678 with no Avalon read.
- write_req and read_req both high -> only avl_write is issued first; the read is issued after DONE.
- Read with avl_rdata_valid never asserted, TIMEOUT=16 -> after 16 cycles err=1, read_data=0xFFFFFFFF, stall drops. err persists until rst is asserted low.
